// File: rtl/booth_multiplier_seq_pkg.sv
// Shared definitions for the sequential radix-4 Booth multiplier:
// FSM state encoding, Booth digit encoding and iteration-count helper.
package booth_multiplier_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PA   = 3'd1,
    P2A  = 3'd2,
    NA   = 3'd3,
    N2A  = 3'd4
  } digit_e;

  // One radix-4 digit per iteration over the (WIDTH+2)-bit extended multiplier.
  function automatic int booth_iters(input int width);
    return (width + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_radix4_encoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b[i+1], b[i], b[i-1]}
// onto zero / double / negate controls for the accumulator adder.
module booth_radix4_encoder
  import booth_multiplier_seq_pkg::*;
(
  input  logic [2:0] win,
  output logic       zero,
  output logic       double,
  output logic       negate
);

  digit_e digit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    digit = ZERO;
    unique case (win)
      3'b000:  digit = ZERO;
      3'b001:  digit = PA;
      3'b010:  digit = PA;
      3'b011:  digit = P2A;
      3'b100:  digit = N2A;
      3'b101:  digit = NA;
      3'b110:  digit = NA;
      3'b111:  digit = ZERO;
      default: digit = ZERO;
    endcase
  end

  // 111 recodes to zero with negate low, so the adder never sees a -0 carry-in.
  assign zero   = (digit == ZERO);
  assign double = (digit == P2A) || (digit == N2A);
  assign negate = (digit == NA)  || (digit == N2A);

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-4 Booth multiplier: one digit per clock over WIDTH+2
// extended bits, signed or unsigned operands, result held until next accept.
module booth_multiplier_seq
  import booth_multiplier_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  input  logic                 Signed,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Out
);

  localparam int E     = WIDTH + 2;
  localparam int N     = booth_iters(WIDTH);
  localparam int CNT_W = $clog2(N + 1);

  if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_bad_width
    $error("booth_multiplier_seq: WIDTH must be even and >= 4");
  end

  state_e               state_q, state_d;
  logic [E-1:0]         a_q, a_d;        // extended multiplicand
  logic [E-1:0]         hi_q, hi_d;      // upper accumulator
  logic [E-1:0]         lo_q, lo_d;      // multiplier, refilled with product bits
  logic                 bm1_q, bm1_d;    // implicit b[-1]
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   out_q, out_d;

  logic                 dig_zero, dig_double, dig_negate;
  logic [E:0]           mult;
  logic [E:0]           addend;
  logic [E:0]           sum;
  logic [E-1:0]         hi_n;
  logic [E-1:0]         lo_n;
  logic [E-1:0]         a_ext;
  logic [E-1:0]         b_ext;
  logic                 accept;
  logic                 last_iter;

  booth_radix4_encoder u_enc (
    .win    ({lo_q[1:0], bm1_q}),
    .zero   (dig_zero),
    .double (dig_double),
    .negate (dig_negate)
  );

  // Single E+1 bit adder; subtraction is ~multiple with carry-in 1.
  always_comb begin
    mult = '0;
    if (!dig_zero) begin
      mult = dig_double ? {a_q, 1'b0} : {a_q[E-1], a_q};
    end
    addend = dig_negate ? ~mult : mult;
    sum    = {hi_q[E-1], hi_q} + addend + {{E{1'b0}}, dig_negate};
    hi_n   = {sum[E], sum[E:2]};
    lo_n   = {sum[1:0], lo_q[E-1:2]};
  end

  assign a_ext     = Signed ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
  assign b_ext     = Signed ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
  assign accept    = Start && (state_q != BUSY);
  assign last_iter = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    bm1_d   = bm1_q;
    cnt_d   = cnt_q;
    out_d   = out_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = BUSY;
          a_d     = a_ext;
          hi_d    = '0;
          lo_d    = b_ext;
          bm1_d   = 1'b0;
          cnt_d   = CNT_W'(N);
        end
      end
      BUSY: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        bm1_d = lo_q[1];
        cnt_d = cnt_q - CNT_W'(1);
        if (last_iter) begin
          state_d = DONE;
          // Low 2*WIDTH bits of {hi_n, lo_n}; the top four bits are sign copies.
          out_d   = {hi_n[E-5:0], lo_n};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset along with the FSM so Out reads 0 after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      bm1_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      bm1_q   <= bm1_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign Busy = (state_q == BUSY);
  assign Done = (state_q == DONE);
  assign Out  = out_q;

  busy_done_exclusive: assert property (@(posedge CLK) disable iff (RST) !(Busy && Done));

endmodule
